// File: rtl/array_wr_arb.sv
// Write-port front end for the 1W/4R register array: datapath/host arbitration plus a zero-fill clear engine.
// Latency: a request accepted in cycle T is on wa/we/di at T+1; clear writes follow clr_req by two cycles.
// Backpressure: combinational dp_rdy/hs_rdy; both low while clearing, datapath held off when the host starves.
module array_wr_arb #(
    parameter int ADDRBIT = 9,
    parameter int DEPTH   = 512,
    parameter int WIDTH   = 32,
    parameter int STARVE  = 4
) (
    input  logic               rst_,
    input  logic               wclk,
    input  logic               clr_req,
    output logic               clr_busy,
    output logic               clr_done,
    input  logic               dp_vld,
    input  logic [ADDRBIT-1:0] dp_addr,
    input  logic [WIDTH-1:0]   dp_data,
    output logic               dp_rdy,
    input  logic               hs_vld,
    input  logic [ADDRBIT-1:0] hs_addr,
    input  logic [WIDTH-1:0]   hs_data,
    output logic               hs_rdy,
    output logic               addr_err,
    output logic [ADDRBIT-1:0] wa,
    output logic               we,
    output logic [WIDTH-1:0]   di
);

    typedef enum logic {IDLE, CLEAR} state_t;

    localparam logic [ADDRBIT:0]   DEPTH_W  = (ADDRBIT+1)'(DEPTH);
    localparam logic [ADDRBIT-1:0] LAST     = ADDRBIT'(DEPTH - 1);
    localparam logic [3:0]         STARVE_C = 4'(STARVE);

    state_t             state_q, state_d;
    logic [ADDRBIT-1:0] clr_cnt_q, clr_cnt_d;
    logic [3:0]         starve_q, starve_d;
    logic [ADDRBIT-1:0] wa_q, wa_d;
    logic               we_q, we_d;
    logic [WIDTH-1:0]   di_q, di_d;
    logic               clr_done_q, clr_done_d;
    logic               addr_err_q, addr_err_d;

    logic               starve_hit;
    logic               dp_acc, hs_acc;
    logic [ADDRBIT-1:0] sel_addr;
    logic [WIDTH-1:0]   sel_data;
    logic               addr_oor;

    assign clr_busy   = (state_q == CLEAR);
    assign starve_hit = (starve_q == STARVE_C) & hs_vld;
    assign dp_rdy     = ~clr_busy & ~starve_hit;
    assign hs_rdy     = ~clr_busy & (~dp_vld | starve_hit);
    assign dp_acc     = dp_vld & dp_rdy;
    assign hs_acc     = hs_vld & hs_rdy;

    // The ready terms make dp_acc and hs_acc mutually exclusive.
    assign sel_addr = dp_acc ? dp_addr : hs_addr;
    assign sel_data = dp_acc ? dp_data : hs_data;
    assign addr_oor = ({1'b0, sel_addr} >= DEPTH_W);

    always_comb begin
        state_d    = state_q;
        clr_cnt_d  = clr_cnt_q;
        starve_d   = starve_q;
        wa_d       = wa_q;
        we_d       = 1'b0;
        di_d       = di_q;
        clr_done_d = 1'b0;
        addr_err_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (dp_acc | hs_acc) begin
                    if (addr_oor) begin
                        addr_err_d = 1'b1;
                    end else begin
                        we_d = 1'b1;
                        wa_d = sel_addr;
                        di_d = sel_data;
                    end
                end

                if (hs_acc | ~hs_vld) begin
                    starve_d = 4'd0;
                end else if (dp_acc && (starve_q != STARVE_C)) begin
                    starve_d = starve_q + 4'd1;
                end

                if (clr_req) begin
                    state_d   = CLEAR;
                    clr_cnt_d = '0;
                end
            end

            CLEAR: begin
                we_d = 1'b1;
                wa_d = clr_cnt_q;
                di_d = '0;
                // Leaving on the last write lets a request accepted now land right behind it.
                if (clr_cnt_q == LAST) begin
                    state_d    = IDLE;
                    clr_done_d = 1'b1;
                    clr_cnt_d  = '0;
                end else begin
                    clr_cnt_d = clr_cnt_q + ADDRBIT'(1);
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge wclk or negedge rst_) begin
        if (!rst_) begin
            state_q    <= IDLE;
            clr_cnt_q  <= '0;
            starve_q   <= 4'd0;
            wa_q       <= '0;
            we_q       <= 1'b0;
            di_q       <= '0;
            clr_done_q <= 1'b0;
            addr_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_cnt_q  <= clr_cnt_d;
            starve_q   <= starve_d;
            wa_q       <= wa_d;
            we_q       <= we_d;
            di_q       <= di_d;
            clr_done_q <= clr_done_d;
            addr_err_q <= addr_err_d;
        end
    end

    assign wa       = wa_q;
    assign we       = we_q;
    assign di       = di_q;
    assign clr_done = clr_done_q;
    assign addr_err = addr_err_q;

endmodule

// File: tb/tb_array_wr_arb.sv
// Directed bench for array_wr_arb at DEPTH=16, STARVE=4 with hand-computed expectations.
module tb_array_wr_arb;

    localparam int AB = 5;
    localparam int W  = 32;

    logic          rst_, wclk;
    logic          clr_req, clr_busy, clr_done;
    logic          dp_vld, dp_rdy, hs_vld, hs_rdy, addr_err, we;
    logic [AB-1:0] dp_addr, hs_addr, wa;
    logic [W-1:0]  dp_data, hs_data, di;

    int vecs = 0;
    int errs = 0;

    array_wr_arb #(.ADDRBIT(AB), .DEPTH(16), .WIDTH(W), .STARVE(4)) dut (
        .rst_(rst_), .wclk(wclk),
        .clr_req(clr_req), .clr_busy(clr_busy), .clr_done(clr_done),
        .dp_vld(dp_vld), .dp_addr(dp_addr), .dp_data(dp_data), .dp_rdy(dp_rdy),
        .hs_vld(hs_vld), .hs_addr(hs_addr), .hs_data(hs_data), .hs_rdy(hs_rdy),
        .addr_err(addr_err), .wa(wa), .we(we), .di(di)
    );

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    task automatic tick;
        @(posedge wclk);
        #1;
    endtask

    task automatic test_reset;
        rst_ = 1'b0; clr_req = 0; dp_vld = 0; hs_vld = 0;
        dp_addr = '0; hs_addr = '0; dp_data = '0; hs_data = '0;
        #2;
        vecs++; if (we !== 1'b0) begin errs++; $display("FAIL reset_we got %b exp 0", we); end
        vecs++; if (wa !== 5'd0) begin errs++; $display("FAIL reset_wa got %h exp 0", wa); end
        vecs++; if (di !== 32'd0) begin errs++; $display("FAIL reset_di got %h exp 0", di); end
        vecs++; if (clr_busy !== 1'b0) begin errs++; $display("FAIL reset_busy got %b exp 0", clr_busy); end
        vecs++; if (clr_done !== 1'b0) begin errs++; $display("FAIL reset_done got %b exp 0", clr_done); end
        vecs++; if (addr_err !== 1'b0) begin errs++; $display("FAIL reset_aerr got %b exp 0", addr_err); end
        vecs++; if (dp_rdy !== 1'b1) begin errs++; $display("FAIL reset_dp_rdy got %b exp 1", dp_rdy); end
        @(negedge wclk); rst_ = 1'b1;
        tick;
    endtask

    task automatic test_single_write;
        dp_vld = 1; dp_addr = 5'd3; dp_data = 32'hA5A5A5A5;
        #1;
        vecs++; if (dp_rdy !== 1'b1) begin errs++; $display("FAIL single_rdy got %b exp 1", dp_rdy); end
        tick; dp_vld = 0;
        vecs++; if (we !== 1'b1) begin errs++; $display("FAIL single_we got %b exp 1", we); end
        vecs++; if (wa !== 5'd3) begin errs++; $display("FAIL single_wa got %h exp 3", wa); end
        vecs++; if (di !== 32'hA5A5A5A5) begin errs++; $display("FAIL single_di got %h exp a5a5a5a5", di); end
        tick;
        vecs++; if (we !== 1'b0) begin errs++; $display("FAIL single_we_off got %b exp 0", we); end
        vecs++; if (wa !== 5'd3) begin errs++; $display("FAIL single_wa_hold got %h exp 3", wa); end
    endtask

    task automatic test_starve;
        logic hs_turn;
        dp_vld = 1; dp_addr = 5'd1; dp_data = 32'h11;
        hs_vld = 1; hs_addr = 5'd2; hs_data = 32'h22;
        for (int i = 0; i < 10; i++) begin
            hs_turn = (i % 5 == 4);
            #1;
            vecs++; if (dp_rdy !== ~hs_turn) begin errs++; $display("FAIL starve_dp_rdy[%0d] got %b exp %b", i, dp_rdy, ~hs_turn); end
            vecs++; if (hs_rdy !== hs_turn) begin errs++; $display("FAIL starve_hs_rdy[%0d] got %b exp %b", i, hs_rdy, hs_turn); end
            tick;
            vecs++; if (we !== 1'b1) begin errs++; $display("FAIL starve_we[%0d] got %b exp 1", i, we); end
            vecs++; if (wa !== (hs_turn ? 5'd2 : 5'd1)) begin errs++; $display("FAIL starve_wa[%0d] got %h exp %h", i, wa, hs_turn ? 5'd2 : 5'd1); end
            vecs++; if (di !== (hs_turn ? 32'h22 : 32'h11)) begin errs++; $display("FAIL starve_di[%0d] got %h exp %h", i, di, hs_turn ? 32'h22 : 32'h11); end
        end
        dp_vld = 0; hs_vld = 0;
        tick;
        vecs++; if (we !== 1'b0) begin errs++; $display("FAIL starve_idle_we got %b exp 0", we); end
    endtask

    task automatic test_clear_with_write;
        int dones = 0;
        dp_vld = 1; dp_addr = 5'd5; dp_data = 32'h55; clr_req = 1;
        #1;
        vecs++; if (dp_rdy !== 1'b1) begin errs++; $display("FAIL clr_T_rdy got %b exp 1", dp_rdy); end
        tick; clr_req = 0; dp_addr = 5'd7; dp_data = 32'h77;
        #1;
        vecs++; if (we !== 1'b1 || wa !== 5'd5 || di !== 32'h55) begin errs++; $display("FAIL clr_T1_write got we=%b wa=%h di=%h exp 1/05/55", we, wa, di); end
        vecs++; if (clr_busy !== 1'b1) begin errs++; $display("FAIL clr_T1_busy got %b exp 1", clr_busy); end
        vecs++; if (dp_rdy !== 1'b0) begin errs++; $display("FAIL clr_T1_rdy got %b exp 0", dp_rdy); end
        for (int k = 0; k < 16; k++) begin
            tick;
            if (clr_done === 1'b1) dones++;
            vecs++; if (we !== 1'b1 || wa !== 5'(k) || di !== 32'd0) begin errs++; $display("FAIL clr_write[%0d] got we=%b wa=%h di=%h exp 1/%h/0", k, we, wa, di, 5'(k)); end
            vecs++; if (clr_done !== (k == 15)) begin errs++; $display("FAIL clr_done[%0d] got %b exp %b", k, clr_done, k == 15); end
            vecs++; if (clr_busy !== (k != 15)) begin errs++; $display("FAIL clr_busy[%0d] got %b exp %b", k, clr_busy, k != 15); end
            vecs++; if (dp_rdy !== (k == 15)) begin errs++; $display("FAIL clr_dp_rdy[%0d] got %b exp %b", k, dp_rdy, k == 15); end
        end
        tick; dp_vld = 0;
        vecs++; if (we !== 1'b1 || wa !== 5'd7 || di !== 32'h77) begin errs++; $display("FAIL clr_post_write got we=%b wa=%h di=%h exp 1/07/77", we, wa, di); end
        vecs++; if (dones != 1 || clr_done !== 1'b0) begin errs++; $display("FAIL clr_done_count got %0d (now %b) exp 1 (now 0)", dones, clr_done); end
    endtask

    task automatic test_addr_err;
        hs_vld = 1; hs_addr = 5'd20; hs_data = 32'h1;
        #1;
        vecs++; if (hs_rdy !== 1'b1) begin errs++; $display("FAIL aerr_rdy got %b exp 1", hs_rdy); end
        tick; hs_vld = 0;
        vecs++; if (we !== 1'b0) begin errs++; $display("FAIL aerr_we got %b exp 0", we); end
        vecs++; if (addr_err !== 1'b1) begin errs++; $display("FAIL aerr_flag got %b exp 1", addr_err); end
        vecs++; if (wa !== 5'd7 || di !== 32'h77) begin errs++; $display("FAIL aerr_hold got wa=%h di=%h exp 07/77", wa, di); end
        tick;
        vecs++; if (addr_err !== 1'b0) begin errs++; $display("FAIL aerr_pulse got %b exp 0", addr_err); end
    endtask

    // Full 16-entry sweep from idle; clr_req is re-raised for one cycle at repulse_k (if >= 0).
    task automatic run_sweep(input string tag, input int repulse_k);
        int dones = 0;
        clr_req = 1;
        tick; clr_req = 0;
        vecs++; if (clr_busy !== 1'b1 || we !== 1'b0) begin errs++; $display("FAIL %s_start got busy=%b we=%b exp 1/0", tag, clr_busy, we); end
        for (int k = 0; k < 16; k++) begin
            clr_req = (k == repulse_k);
            tick;
            if (clr_done === 1'b1) dones++;
            vecs++; if (we !== 1'b1 || wa !== 5'(k) || di !== 32'd0) begin errs++; $display("FAIL %s_write[%0d] got we=%b wa=%h di=%h exp 1/%h/0", tag, k, we, wa, di, 5'(k)); end
            vecs++; if (clr_done !== (k == 15)) begin errs++; $display("FAIL %s_done[%0d] got %b exp %b", tag, k, clr_done, k == 15); end
        end
        clr_req = 0;
        tick;
        vecs++; if (we !== 1'b0 || clr_busy !== 1'b0) begin errs++; $display("FAIL %s_end got we=%b busy=%b exp 0/0", tag, we, clr_busy); end
        vecs++; if (dones != 1) begin errs++; $display("FAIL %s_done_count got %0d exp 1", tag, dones); end
    endtask

    task automatic test_reset_mid_clear;
        clr_req = 1;
        tick; clr_req = 0;
        repeat (7) tick;
        vecs++; if (we !== 1'b1 || wa !== 5'd6) begin errs++; $display("FAIL midrst_pre got we=%b wa=%h exp 1/06", we, wa); end
        rst_ = 1'b0;
        #1;
        vecs++; if (we !== 1'b0 || clr_busy !== 1'b0 || clr_done !== 1'b0) begin errs++; $display("FAIL midrst_drop got we=%b busy=%b done=%b exp 0/0/0", we, clr_busy, clr_done); end
        vecs++; if (wa !== 5'd0) begin errs++; $display("FAIL midrst_wa got %h exp 0", wa); end
        #2; rst_ = 1'b1;
        tick;
        vecs++; if (clr_done !== 1'b0 || clr_busy !== 1'b0) begin errs++; $display("FAIL midrst_after got busy=%b done=%b exp 0/0", clr_busy, clr_done); end
        run_sweep("resweep", -1);
    endtask

    task automatic test_clear_repulse;
        run_sweep("repulse", 5);
    endtask

    initial begin
        test_reset;
        test_single_write;
        test_starve;
        test_clear_with_write;
        test_addr_err;
        test_reset_mid_clear;
        test_clear_repulse;
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/array_wr_arb.md
Name: array_wr_arb

Overview:
- Write-port front end for the 1-write/4-read register array.
- Produces a single registered write stream (wa/we/di) from two requesters: a datapath source and a host/CPU source.
- Contains a clear engine that sweeps every array address to zero on command.
- Drives the array write port directly, on the same wclk domain.

Parameters:
ADDRBIT, 9, address width (matches array)
DEPTH, 512, number of array entries; legal addresses 0..DEPTH-1
WIDTH, 32, data width
STARVE, 4, consecutive datapath grants while host is pending before the host is forced a grant (1..15)

Ports:
rst_  input  1  asynchronous active-low reset
wclk  input  1  clock; all logic on rising edge
clr_req  input  1  start clear sweep (sampled level, 1 cycle)
clr_busy  output  1  clear sweep in progress
clr_done  output  1  1-cycle pulse coincident with last clear write
dp_vld  input  1  datapath write request
dp_addr  input  ADDRBIT  datapath write address
dp_data  input  WIDTH  datapath write data
dp_rdy  output  1  datapath request accepted when dp_vld&dp_rdy
hs_vld  input  1  host write request
hs_addr  input  ADDRBIT  host write address
hs_data  input  WIDTH  host write data
hs_rdy  output  1  host request accepted when hs_vld&hs_rdy
addr_err  output  1  1-cycle pulse: accepted request had address >= DEPTH
wa  output  ADDRBIT  array write address
we  output  1  array write enable
di  output  WIDTH  array write data

Behaviour:
- Reset (async, rst_=0): state IDLE, clear counter 0, starve counter 0. Outputs: wa=0, we=0, di=0, clr_busy=0, clr_done=0, addr_err=0.
- State machine: IDLE, CLEAR. clr_busy is the registered state bit (1 in CLEAR).
- Ready logic is combinational:
  - dp_rdy = ~clr_busy & ~starve_hit
  - hs_rdy = ~clr_busy & (~dp_vld | starve_hit)
  - starve_hit = (starve_cnt == STARVE) & hs_vld
- At most one source is accepted per cycle. Default priority is datapath over host.
- Starve counter:
  - Increments each cycle dp is accepted while hs_vld=1.
  - Clears when the host is accepted or hs_vld=0.
  - Saturates at STARVE.
- Write latency: a request accepted in cycle T appears on wa/di with we=1 in cycle T+1. we=0 in any cycle following no acceptance.
- Out-of-range address (>= DEPTH): the request is still handshaken (accepted). At T+1: we=0, addr_err=1, wa/di hold their previous values.
- Clear sweep:
  - clr_req=1 in IDLE at cycle T is accepted. A source request accepted in the same cycle T is still written at T+1.
  - T+1: state=CLEAR, clr_busy=1, both rdy=0.
  - Clear writes appear at T+2..T+1+DEPTH with wa=0..DEPTH-1 ascending, di=0, we=1.
  - State returns to IDLE at T+1+DEPTH. clr_done=1 and clr_busy=0 in that cycle, so new requests can be accepted at T+1+DEPTH and appear at T+2+DEPTH (no collision).
- clr_req while in CLEAR is ignored (no restart, no queue).
- The clear counter is ADDRBIT wide and stops at DEPTH-1. For non-power-of-2 DEPTH it never reaches unused codes.
- Starve counter holds its value during CLEAR.
- Reset mid-sweep aborts immediately to IDLE with all outputs at reset values; clr_done is not issued.
- rdy signals never depend on the same-cycle clr_req; clr_req only takes effect from the next cycle.

Test Plan:
- DEPTH=16, STARVE=4.
- Reset, then dp_vld=1, dp_addr=3, dp_data=0xA5A5A5A5 for 1 cycle -> next cycle we=1, wa=3, di=0xA5A5A5A5; the following cycle we=0.
- dp_vld and hs_vld held high continuously (dp_addr=1, hs_addr=2) -> grant pattern dp,dp,dp,dp,hs repeating. In the hs cycle dp_rdy=0; we is high every cycle.
- clr_req pulse at T with dp_vld accepted at T (addr 5) -> wa=5 at T+1; wa=0..15 with di=0 at T+2..T+17; clr_done=1 only at T+17; clr_busy=1 at T+1..T+16; dp_rdy=0 at T+1..T+16.
- hs_vld=1, hs_addr=20 (>= DEPTH), hs_data=0x1 -> hs_rdy=1; next cycle we=0, addr_err=1, wa/di unchanged.
- Assert rst_=0 during CLEAR at counter=7 -> we, clr_busy and clr_done drop to 0 immediately. After release, a second clr_req runs a full sweep from wa=0.
- clr_req re-pulsed mid-sweep -> sweep length unchanged (16 writes); exactly one clr_done.
